// File: rtl/alt_vipitc131_common_thresh_fifo_pkg.sv
// Shared types and helpers for the VIP ITC threshold FIFO.
package alt_vipitc131_common_thresh_fifo_pkg;

  // Show-ahead output register occupancy.
  typedef enum logic {
    EMPTY_OUT = 1'b0,
    FULL_OUT  = 1'b1
  } prefetch_state_e;

  // Ceiling log2, minimum 1, used to size addresses and counts.
  function automatic int unsigned alt_clogb2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v != 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/alt_vipitc131_common_sdp_ram.sv
// Simple dual-port RAM with registered, enable-gated read port.
module alt_vipitc131_common_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned PTR_WIDTH  = 11,
  parameter int unsigned FIFO_DEPTH = 1920
) (
  input  logic                  clock_i,
  input  logic                  aclr_i,
  input  logic                  sclr_i,
  input  logic                  wr_en_i,
  input  logic [PTR_WIDTH-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [PTR_WIDTH-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clock_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read data register: holds its value until the next enabled read.
  always_ff @(posedge clock_i or posedge aclr_i) begin
    if (aclr_i)       rd_data_q <= '0;
    else if (sclr_i)  rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/alt_vipitc131_common_thresh_fifo.sv
// Single-clock FIFO with thresholds, sticky errors and optional show-ahead.
module alt_vipitc131_common_thresh_fifo
  import alt_vipitc131_common_thresh_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH         = 20,
  parameter  int unsigned FIFO_DEPTH         = 1920,
  parameter  int unsigned SHOWAHEAD          = 0,
  parameter  int unsigned ALMOST_FULL_LEVEL  = 1800,
  parameter  int unsigned ALMOST_EMPTY_LEVEL = 16,
  localparam int unsigned PTR_WIDTH          = alt_clogb2(FIFO_DEPTH),
  localparam int unsigned USEDW_WIDTH        = alt_clogb2(FIFO_DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   sclr,
  input  logic                   wrreq,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   rdreq,
  output logic [DATA_WIDTH-1:0]  q,
  output logic [USEDW_WIDTH-1:0] usedw,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [PTR_WIDTH-1:0]   LAST_PTR = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [USEDW_WIDTH-1:0] DEPTH_W  = USEDW_WIDTH'(FIFO_DEPTH);
  localparam logic [USEDW_WIDTH-1:0] AF_W     = USEDW_WIDTH'(ALMOST_FULL_LEVEL);
  localparam logic [USEDW_WIDTH-1:0] AE_W     = USEDW_WIDTH'(ALMOST_EMPTY_LEVEL);

  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [USEDW_WIDTH-1:0] usedw_q, usedw_d;
  logic full_q, full_d, afull_q, afull_d, aempty_q, aempty_d;
  logic empty_q, empty_d, ovf_q, ovf_d, udf_q, udf_d;
  logic wr_acc, rd_acc, ram_rd;

  // Request acceptance against the registered flags.
  always_comb begin
    wr_acc = wrreq & ~full_q;
    rd_acc = rdreq & ~empty_q;
  end

  // Occupancy count and the flags derived from its next value.
  always_comb begin
    usedw_d = usedw_q;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + USEDW_WIDTH'(1);
      2'b01:   usedw_d = usedw_q - USEDW_WIDTH'(1);
      default: usedw_d = usedw_q;
    endcase
    full_d   = (usedw_d == DEPTH_W);
    afull_d  = (usedw_d >= AF_W);
    aempty_d = (usedw_d <= AE_W);
    ovf_d    = ovf_q | (wrreq & full_q);
    udf_d    = udf_q | (rdreq & empty_q);
  end

  // RAM pointers with explicit wrap at the last storage word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    if (ram_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
  end

  // Pointer, count, flag and sticky-error registers.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; usedw_q <= '0;
      full_q <= 1'b0; afull_q <= 1'b0; aempty_q <= 1'b1; empty_q <= 1'b1;
      ovf_q <= 1'b0; udf_q <= 1'b0;
    end else if (sclr) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; usedw_q <= '0;
      full_q <= 1'b0; afull_q <= 1'b0; aempty_q <= 1'b1; empty_q <= 1'b1;
      ovf_q <= 1'b0; udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; usedw_q <= usedw_d;
      full_q <= full_d; afull_q <= afull_d; aempty_q <= aempty_d; empty_q <= empty_d;
      ovf_q <= ovf_d; udf_q <= udf_d;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // The RAM holds ram_cnt words; usedw also includes the word in the
      // output register, so empty follows the prefetch state, not usedw.
      prefetch_state_e        state_q, state_d;
      logic [USEDW_WIDTH-1:0] ram_cnt_q, ram_cnt_d;

      // Prefetch control: keep the output register loaded with the head word.
      always_comb begin
        state_d = state_q;
        ram_rd  = 1'b0;
        case (state_q)
          EMPTY_OUT: if (ram_cnt_q != '0) begin
                       ram_rd  = 1'b1;
                       state_d = FULL_OUT;
                     end
          FULL_OUT:  if (rd_acc) begin
                       if (ram_cnt_q != '0) ram_rd = 1'b1;
                       else                 state_d = EMPTY_OUT;
                     end
          default:   state_d = EMPTY_OUT;
        endcase
        case ({wr_acc, ram_rd})
          2'b10:   ram_cnt_d = ram_cnt_q + USEDW_WIDTH'(1);
          2'b01:   ram_cnt_d = ram_cnt_q - USEDW_WIDTH'(1);
          default: ram_cnt_d = ram_cnt_q;
        endcase
        empty_d = (state_d != FULL_OUT);
      end

      // Prefetch state and RAM-resident word count.
      always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
          state_q <= EMPTY_OUT; ram_cnt_q <= '0;
        end else if (sclr) begin
          state_q <= EMPTY_OUT; ram_cnt_q <= '0;
        end else begin
          state_q <= state_d; ram_cnt_q <= ram_cnt_d;
        end
      end
    end else begin : g_normal
      // Normal mode: every accepted read fetches straight from the RAM.
      always_comb begin
        ram_rd  = rd_acc;
        empty_d = (usedw_d == '0);
      end
    end
  endgenerate

  alt_vipitc131_common_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clock_i   (clock),
    .aclr_i    (aclr),
    .sclr_i    (sclr),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data),
    .rd_en_i   (ram_rd),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (q)
  );

  assign usedw        = usedw_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
